// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_arbiter_if
// Description : Request/response handshake bundle for the two-port shared
//               saturating add/subtract unit. The slave modport is the
//               arbiter; the master modport is the requester/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_arbiter_if #(
    parameter int WIDTH = 16
);
    // Port 0 request
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    // Port 1 request
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;
    // Port 0 response
    logic             resp0_valid;
    logic             resp0_ready;
    logic [WIDTH-1:0] resp0_sum;
    logic             resp0_ovf;
    // Port 1 response
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp1_sum;
    logic             resp1_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        output resp0_valid, resp0_sum, resp0_ovf,
        input  resp0_ready,
        output resp1_valid, resp1_sum, resp1_ovf,
        input  resp1_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        input  resp0_valid, resp0_sum, resp0_ovf,
        output resp0_ready,
        input  resp1_valid, resp1_sum, resp1_ovf,
        output resp1_ready
    );
endinterface
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cla_16bit / addsub_arbiter
// Description : One 16-bit carry-lookahead adder shared by two requesters
//               through a round-robin arbiter. Each accepted request is
//               executed once, saturated to signed 16-bit range and held on
//               the owner's response port until the consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================

// 16-bit adder: four 4-bit lookahead groups with a second lookahead level
// across the groups, so no carry ripples between groups.
module cla_16bit (
    input  wire logic [15:0] a,
    input  wire logic [15:0] b,
    input  wire logic        cin,
    output logic      [15:0] sum,
    output logic             cout
);
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_c;
    logic [3:0]  w_grp_p;
    logic [3:0]  w_grp_g;
    logic [4:0]  w_gc;

    assign w_p = a ^ b;
    assign w_g = a & b;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grp
            logic [3:0] w_gp;
            logic [3:0] w_gg;
            logic       w_ci;
            assign w_gp = w_p[4*gi +: 4];
            assign w_gg = w_g[4*gi +: 4];
            assign w_ci = w_gc[gi];
            assign w_grp_p[gi] = &w_gp;
            assign w_grp_g[gi] = w_gg[3] | (w_gp[3] & w_gg[2])
                               | (w_gp[3] & w_gp[2] & w_gg[1])
                               | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
            assign w_c[4*gi]   = w_ci;
            assign w_c[4*gi+1] = w_gg[0] | (w_gp[0] & w_ci);
            assign w_c[4*gi+2] = w_gg[1] | (w_gp[1] & w_gg[0])
                               | (w_gp[1] & w_gp[0] & w_ci);
            assign w_c[4*gi+3] = w_gg[2] | (w_gp[2] & w_gg[1])
                               | (w_gp[2] & w_gp[1] & w_gg[0])
                               | (w_gp[2] & w_gp[1] & w_gp[0] & w_ci);
        end
    endgenerate

    // Second-level lookahead: group carries in closed form from cin.
    assign w_gc[0] = cin;
    assign w_gc[1] = w_grp_g[0] | (w_grp_p[0] & cin);
    assign w_gc[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0])
                   | (w_grp_p[1] & w_grp_p[0] & cin);
    assign w_gc[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1])
                   | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                   | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & cin);
    assign w_gc[4] = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
                   | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                   | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                   | (&w_grp_p & cin);

    assign sum  = w_p ^ w_c;
    assign cout = w_gc[4];
endmodule

module addsub_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    addsub_arbiter_if.slave       bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      cnt0,
    output logic [CNT_W-1:0]      cnt1
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_owner;
    logic [WIDTH-1:0] r_sum0;
    logic             r_ovf0;
    logic [WIDTH-1:0] r_sum1;
    logic             r_ovf1;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_rdy0;
    logic             w_rdy1;
    logic             w_accept;
    logic             w_resp_hs;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_raw;
    logic             w_unused_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sat;

    // Subtraction is A + ~B + 1, so the carry-in doubles as the sub flag.
    assign w_b_eff = r_sub ? ~r_b : r_b;

    cla_16bit u_cla (
        .a    (r_a),
        .b    (w_b_eff),
        .cin  (r_sub),
        .sum  (w_raw),
        .cout (w_unused_cout)
    );

    // Signed overflow and clamp toward the sign of operand A.
    always_comb begin
        w_ovf = 1'b0;
        w_sat = w_raw;
        if (r_sub) begin
            w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_raw[WIDTH-1] != r_a[WIDTH-1]);
        end else begin
            w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_raw[WIDTH-1] != r_a[WIDTH-1]);
        end
        if (w_ovf) begin
            w_sat = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant, handshake outputs and next state. Readies are also gated by
    // rst_n so nothing is offered while reset is asserted.
    always_comb begin
        w_next          = r_state;
        w_rdy0          = 1'b0;
        w_rdy1          = 1'b0;
        w_resp_hs       = 1'b0;
        bus.resp0_valid = 1'b0;
        bus.resp1_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rdy0 = rst_n && bus.req0_valid && (!bus.req1_valid || r_last_grant);
                w_rdy1 = rst_n && bus.req1_valid && (!bus.req0_valid || !r_last_grant);
                if (w_rdy0 || w_rdy1) begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                bus.resp0_valid = !r_owner;
                bus.resp1_valid = r_owner;
                w_resp_hs = r_owner ? bus.resp1_ready : bus.resp0_ready;
                if (w_resp_hs) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept       = w_rdy0 | w_rdy1;
    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;

    // Operand capture on accept and per-port result capture at end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= 1'b0;
            r_owner      <= 1'b0;
            r_sum0       <= '0;
            r_ovf0       <= 1'b0;
            r_sum1       <= '0;
            r_ovf1       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a          <= w_rdy1 ? bus.req1_a   : bus.req0_a;
                r_b          <= w_rdy1 ? bus.req1_b   : bus.req0_b;
                r_sub        <= w_rdy1 ? bus.req1_sub : bus.req0_sub;
                r_owner      <= w_rdy1;
                r_last_grant <= w_rdy1;
            end
            if (r_state == ST_EXEC) begin
                if (r_owner) begin
                    r_sum1 <= w_sat;
                    r_ovf1 <= w_ovf;
                end else begin
                    r_sum0 <= w_sat;
                    r_ovf0 <= w_ovf;
                end
            end
        end
    end

    // Completed-operation counters, one per port, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_resp_hs) begin
            if (r_owner) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end else begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
        end
    end

    assign bus.resp0_sum = r_sum0;
    assign bus.resp0_ovf = r_ovf0;
    assign bus.resp1_sum = r_sum1;
    assign bus.resp1_ovf = r_ovf1;
    assign busy          = (r_state != ST_IDLE);
    assign cnt0          = r_cnt0;
    assign cnt1          = r_cnt1;
endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_arbiter
// Description : Directed self-checking bench for addsub_arbiter (CNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    int         tests = 0;
    int         fails = 0;

    addsub_arbiter_if #(.WIDTH(16)) bus ();

    addsub_arbiter #(.WIDTH(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .cnt0  (cnt0),
        .cnt1  (cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 0;
        bus.resp0_ready = 0; bus.resp1_ready = 0;
    endtask

    task automatic apply_reset;
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Runs one request on a port and returns the response; only the
    // handshake waits are checked here (bounded, failure on expiry).
    task automatic do_op(input bit port, input logic [15:0] a, input logic [15:0] b,
                         input bit sub, output logic [15:0] sum, output logic ovf);
        bit seen;
        @(posedge clk); #1;
        if (!port) begin
            bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.resp0_ready = 1;
        end else begin
            bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.resp1_ready = 1;
        end
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((port ? bus.req1_ready : bus.req0_ready) === 1'b1) begin seen = 1; break; end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL op_grant_timeout port %0d: ready not seen, required 1", port); end
        @(posedge clk); #1;
        if (!port) bus.req0_valid = 0; else bus.req1_valid = 0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((port ? bus.resp1_valid : bus.resp0_valid) === 1'b1) begin seen = 1; break; end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL op_resp_timeout port %0d: resp_valid not seen, required 1", port); end
        sum = port ? bus.resp1_sum : bus.resp0_sum;
        ovf = port ? bus.resp1_ovf : bus.resp0_ovf;
        @(posedge clk); #1;
        if (!port) bus.resp0_ready = 0; else bus.resp1_ready = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        bus.req0_valid = 1; bus.req1_valid = 1;
        #2;
        tests++; if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL reset_req0_ready: got %b required 0", bus.req0_ready); end
        tests++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL reset_req1_ready: got %b required 0", bus.req1_ready); end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
        tests++; if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin fails++; $display("FAIL reset_resp_valid: got %b required 00", {bus.resp0_valid, bus.resp1_valid}); end
        tests++; if ({bus.resp0_sum, bus.resp1_sum} !== 32'h0) begin fails++; $display("FAIL reset_sums: got %h required 0", {bus.resp0_sum, bus.resp1_sum}); end
        tests++; if ({bus.resp0_ovf, bus.resp1_ovf} !== 2'b00) begin fails++; $display("FAIL reset_ovf: got %b required 00", {bus.resp0_ovf, bus.resp1_ovf}); end
        tests++; if ({cnt0, cnt1} !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %h required 0", {cnt0, cnt1}); end
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_basic_add;
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_a = 16'h1234; bus.req0_b = 16'h0F0F; bus.req0_sub = 0; bus.resp0_ready = 1;
        @(negedge clk);
        tests++; if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL add_ready: got %b required 1", bus.req0_ready); end
        @(posedge clk); #1;                      // accept edge E0
        bus.req0_valid = 0;
        @(negedge clk);
        tests++; if ({busy, bus.resp0_valid} !== 2'b10) begin fails++; $display("FAIL add_exec: busy/resp_valid got %b required 10", {busy, bus.resp0_valid}); end
        @(posedge clk); #1;                      // E1
        @(negedge clk);
        tests++; if (bus.resp0_valid !== 1'b1) begin fails++; $display("FAIL add_latency: resp0_valid got %b required 1", bus.resp0_valid); end
        tests++; if (bus.resp0_sum !== 16'h2143) begin fails++; $display("FAIL add_sum: got %h required 2143", bus.resp0_sum); end
        tests++; if (bus.resp0_ovf !== 1'b0) begin fails++; $display("FAIL add_ovf: got %b required 0", bus.resp0_ovf); end
        tests++; if (bus.resp1_valid !== 1'b0) begin fails++; $display("FAIL add_other_valid: got %b required 0", bus.resp1_valid); end
        @(posedge clk); #1;                      // handshake
        bus.resp0_ready = 0;
        @(negedge clk);
        tests++; if ({busy, bus.resp0_valid} !== 2'b00) begin fails++; $display("FAIL add_done: busy/resp_valid got %b required 00", {busy, bus.resp0_valid}); end
        tests++; if (cnt0 !== 8'd1) begin fails++; $display("FAIL add_cnt0: got %0d required 1", cnt0); end
    endtask

    task automatic test_saturation;
        logic [15:0] s; logic o;
        do_op(1, 16'h7FFF, 16'h0001, 0, s, o);
        tests++; if ({o, s} !== {1'b1, 16'h7FFF}) begin fails++; $display("FAIL sat_pos_add: got ovf=%b sum=%h required ovf=1 sum=7fff", o, s); end
        do_op(1, 16'h8000, 16'h0001, 1, s, o);
        tests++; if ({o, s} !== {1'b1, 16'h8000}) begin fails++; $display("FAIL sat_neg_sub: got ovf=%b sum=%h required ovf=1 sum=8000", o, s); end
        do_op(0, 16'h8000, 16'hFFFF, 0, s, o);
        tests++; if ({o, s} !== {1'b1, 16'h8000}) begin fails++; $display("FAIL sat_neg_add: got ovf=%b sum=%h required ovf=1 sum=8000", o, s); end
        do_op(0, 16'h7FFF, 16'hFFFF, 1, s, o);
        tests++; if ({o, s} !== {1'b1, 16'h7FFF}) begin fails++; $display("FAIL sat_pos_sub: got ovf=%b sum=%h required ovf=1 sum=7fff", o, s); end
        tests++; if (cnt1 !== 8'd2) begin fails++; $display("FAIL sat_cnt1: got %0d required 2", cnt1); end
    endtask

    task automatic test_back_to_back;
        bit q[$];
        apply_reset();
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_a = 16'h0100; bus.req0_b = 16'h0001; bus.req0_sub = 0; bus.resp0_ready = 1;
        bus.req1_valid = 1; bus.req1_a = 16'h0050; bus.req1_b = 16'h0010; bus.req1_sub = 1; bus.resp1_ready = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            tests++; if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin fails++; $display("FAIL b2b_one_ready cycle %0d: both ready", c); end
            tests++; if ((busy & (bus.req0_ready | bus.req1_ready)) !== 1'b0) begin fails++; $display("FAIL b2b_ready_when_busy cycle %0d: ready high while busy", c); end
            if (bus.req0_ready === 1'b1) q.push_back(1'b0);
            if (bus.req1_ready === 1'b1) q.push_back(1'b1);
            if (bus.resp0_valid === 1'b1) begin
                tests++; if (bus.resp0_sum !== 16'h0101) begin fails++; $display("FAIL b2b_sum0: got %h required 0101", bus.resp0_sum); end
            end
            if (bus.resp1_valid === 1'b1) begin
                tests++; if (bus.resp1_sum !== 16'h0040) begin fails++; $display("FAIL b2b_sum1: got %h required 0040", bus.resp1_sum); end
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        tests++;
        if (q.size() != 4) begin
            fails++; $display("FAIL b2b_grant_count: got %0d required 4", q.size());
        end else if ({q[0], q[1], q[2], q[3]} !== 4'b0101) begin
            fails++; $display("FAIL b2b_grant_order: got %b required 0101", {q[0], q[1], q[2], q[3]});
        end
    endtask

    task automatic test_resp_stall;
        apply_reset();
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_a = 16'h0003; bus.req0_b = 16'h0004; bus.req0_sub = 0; bus.resp0_ready = 0;
        bus.req1_valid = 1; bus.req1_a = 16'h0010; bus.req1_b = 16'h0001; bus.req1_sub = 1; bus.resp1_ready = 1;
        @(negedge clk);
        tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin fails++; $display("FAIL stall_first_grant: got %b required 10", {bus.req0_ready, bus.req1_ready}); end
        @(posedge clk); #1;
        bus.req0_valid = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++; if ({bus.resp0_valid, bus.resp1_valid, bus.req1_ready} !== 3'b100) begin fails++; $display("FAIL stall_hold cycle %0d: valid0/valid1/ready1 got %b required 100", c, {bus.resp0_valid, bus.resp1_valid, bus.req1_ready}); end
            tests++; if (bus.resp0_sum !== 16'h0007) begin fails++; $display("FAIL stall_sum cycle %0d: got %h required 0007", c, bus.resp0_sum); end
            @(posedge clk); #1;
        end
        bus.resp0_ready = 1;
        @(posedge clk); #1;                      // handshake edge
        bus.resp0_ready = 0;
        @(negedge clk);
        tests++; if ({bus.req1_ready, bus.resp0_valid} !== 2'b10) begin fails++; $display("FAIL stall_next_grant: ready1/valid0 got %b required 10", {bus.req1_ready, bus.resp0_valid}); end
        @(posedge clk); #1;
        bus.req1_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if ({bus.resp1_valid, bus.resp1_sum} !== {1'b1, 16'h000F}) begin fails++; $display("FAIL stall_port1_resp: got valid=%b sum=%h required valid=1 sum=000f", bus.resp1_valid, bus.resp1_sum); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1;
        bus.req1_valid = 1; bus.req1_a = 16'h1111; bus.req1_b = 16'h2222; bus.req1_sub = 0; bus.resp1_ready = 1;
        @(negedge clk);
        tests++; if (bus.req1_ready !== 1'b1) begin fails++; $display("FAIL areset_pre_grant: got %b required 1", bus.req1_ready); end
        @(posedge clk); #1;
        bus.req1_valid = 0;
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL areset_in_exec: busy got %b required 1", busy); end
        bus.req0_valid = 1; bus.req1_valid = 1;
        #2 rst_n = 0;
        #1;
        tests++; if ({busy, bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid} !== 5'b0) begin fails++; $display("FAIL areset_ctrl: busy/rdy0/rdy1/val0/val1 got %b required 00000", {busy, bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid}); end
        tests++; if ({bus.resp0_sum, bus.resp1_sum, bus.resp0_ovf, bus.resp1_ovf} !== 34'h0) begin fails++; $display("FAIL areset_data: got %h required 0", {bus.resp0_sum, bus.resp1_sum, bus.resp0_ovf, bus.resp1_ovf}); end
        tests++; if ({cnt0, cnt1} !== 16'h0) begin fails++; $display("FAIL areset_cnt: got %h required 0", {cnt0, cnt1}); end
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++; if ({busy, bus.resp1_valid} !== 2'b00) begin fails++; $display("FAIL areset_no_resp cycle %0d: busy/valid1 got %b required 00", c, {busy, bus.resp1_valid}); end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_a = 16'h0002; bus.req0_b = 16'h0003; bus.req0_sub = 0; bus.resp0_ready = 1;
        bus.req1_valid = 1; bus.req1_a = 16'h0009; bus.req1_b = 16'h0001; bus.req1_sub = 0;
        @(negedge clk);
        tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin fails++; $display("FAIL areset_tie: got %b required 10", {bus.req0_ready, bus.req1_ready}); end
        @(posedge clk); #1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if ({bus.resp0_valid, bus.resp0_sum} !== {1'b1, 16'h0005}) begin fails++; $display("FAIL areset_after: got valid=%b sum=%h required valid=1 sum=0005", bus.resp0_valid, bus.resp0_sum); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_sub_and_wrap;
        logic [15:0] s; logic o;
        do_op(0, 16'h0005, 16'h0007, 1, s, o);
        tests++; if ({o, s} !== {1'b0, 16'hFFFE}) begin fails++; $display("FAIL sub_neg: got ovf=%b sum=%h required ovf=0 sum=fffe", o, s); end
        apply_reset();
        for (int i = 0; i < 255; i++) do_op(0, 16'(i), 16'h0001, 0, s, o);
        tests++; if (cnt0 !== 8'd255) begin fails++; $display("FAIL wrap_cnt255: got %0d required 255", cnt0); end
        tests++; if ({o, s} !== {1'b0, 16'h00FF}) begin fails++; $display("FAIL wrap_last_sum: got ovf=%b sum=%h required ovf=0 sum=00ff", o, s); end
        do_op(0, 16'h00FF, 16'h0001, 0, s, o);
        tests++; if (cnt0 !== 8'd0) begin fails++; $display("FAIL wrap_cnt0: got %0d required 0", cnt0); end
        tests++; if (s !== 16'h0100) begin fails++; $display("FAIL wrap_sum: got %h required 0100", s); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_saturation();
        test_back_to_back();
        test_resp_stall();
        test_async_reset();
        test_sub_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 16-bit saturating add/subtract datapath (cla_16bit) between two requesters, e.g. ALU path (port 0) and address-calc path (port 1).
- Round-robin arbitration with a valid/ready request handshake on each port.
- Operands are registered, the sum is registered, and the response is held per port until accepted.
- Sits beside the execute stage so a single adder instance serves both users.

Parameters:
- WIDTH, 16, operand/result width; fixed at 16 to match cla_16bit.
- CNT_W, 16, width of per-port completed-operation counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a  in  16  port 0 operand A.
- req0_b  in  16  port 0 operand B.
- req0_sub  in  1  port 0: 1 = A-B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as port 0, for port 1.
- resp0_valid  out  1  port 0 result valid.
- resp0_ready  in  1  port 0 consumer accepts result.
- resp0_sum  out  16  port 0 saturated result.
- resp0_ovf  out  1  port 0 saturation occurred.
- resp1_valid, resp1_ready, resp1_sum, resp1_ovf: same as port 0, for port 1.
- busy  out  1  state != IDLE.
- cnt0  out  CNT_W  completed port 0 ops (response handshakes).
- cnt1  out  CNT_W  completed port 1 ops (response handshakes).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - Operand, owner and result registers cleared; cnt0=cnt1=0.
  - All ready/valid outputs 0; resp sums 0; ovf 0; busy 0.
- Reset mid-operation discards any in-flight or held result. No response is ever issued for it.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, request readiness:
  - reqX_ready is combinational and high only for the granted port.
  - Only one ready is high in any cycle; no ready is high outside IDLE.
- IDLE, grant rule:
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
- IDLE, on the edge where reqX_valid && reqX_ready:
  - latch a, b, sub and owner=X; last_grant<=X; go to EXEC.
- EXEC:
  - cla_16bit evaluates the latched operands (cin=sub).
  - At the next edge, latch sum and ovf into the result register; go to RESP.
- RESP:
  - respX_valid=1 for owner X only; the other port's resp_valid stays 0.
  - respX_sum/respX_ovf stay stable until the handshake.
  - On the edge with respX_ready high: cntX<=cntX+1 (wraps at 2^CNT_W); go to IDLE.
  - If respX_ready is already high on entry to RESP, the handshake completes at the first RESP edge.
- Latency: accept edge E0 -> resp_valid high after edge E1 (one cycle later). Minimum spacing between accepts is 3 cycles.
- Arithmetic:
  - Result is the signed two's-complement A+B or A-B, saturated.
  - Positive overflow -> 0x7FFF; negative overflow -> 0x8000.
  - ovf=1 exactly when saturation occurred:
    - add: a[15]==b[15] and the wrap-around sum's bit 15 != a[15].
    - sub: a[15]!=b[15] and the wrap-around difference's bit 15 != a[15].
  - ovf is computed in this block from the latched operands.
- Requester rules:
  - Must hold a, b and sub stable while valid && !ready.
  - May drop valid before grant; nothing is then latched.
  - Fairness: a continuously requesting port waits at most one other operation.
- Unused resp outputs (non-owner port, or not in RESP): sum and ovf hold their last value; only valid is meaningful.

Test Plan:
- Port 0 add 0x1234+0x0F0F, resp0_ready=1 -> resp0_valid after edge E1, sum=0x2143, ovf=0, cnt0=1.
- Port 1 add 0x7FFF+0x0001 -> sum=0x7FFF, ovf=1. Then sub 0x8000-0x0001 -> sum=0x8000, ovf=1.
- Both ports valid in the same cycle after reset, continuously:
  - grants go 0,1,0,1;
  - each resp matches its own operands;
  - no req_ready in EXEC/RESP.
- resp0_ready held low 5 cycles in RESP:
  - resp0_valid and sum stay stable;
  - req1 stays not-ready;
  - after the handshake, port 1 is granted next cycle.
- rst_n asserted asynchronously in EXEC:
  - all outputs are 0 immediately;
  - no response appears after release;
  - the next request is served normally and port 0 wins a tie.
- Sub 0x0005-0x0007 -> sum=0xFFFE, ovf=0. Then 256 port-0 ops with CNT_W=8 -> cnt0 wraps to 0.
